// File: rtl/trig_monitor.sv
// Trigger-line receiver: synchronises trig_in, counts accepted rising edges, measures their period
// and flags a stalled trigger. Define TRIG_DEGLITCH_EN to add the input stability filter.
module trig_monitor #(
    parameter int N_EXPECT        = 1000,
    parameter int TIMEOUT         = 5000000,
    parameter int DEGLITCH_CYCLES = 4
) (
    input  logic        clki,
    input  logic        rst_n,
    input  logic        trig_in,
    input  logic [31:0] ep_ctrl,
    output logic        trig_seen,
    output logic [31:0] trig_count,
    output logic [31:0] last_period,
    output logic [31:0] ep_status
);
    // state | meaning
    // IDLE  | edges ignored, waiting for arm
    // ARMED | counters cleared, waiting for the first edge (no timeout)
    // RUN   | counting edges, measuring period, watching for a stall
    // DONE  | N_EXPECT edges seen, outputs held
    // TOUT  | no edge for TIMEOUT cycles, outputs held
    typedef enum logic [2:0] {IDLE, ARMED, RUN, DONE, TOUT} state_t;

    localparam logic [31:0] N_EXP     = 32'(N_EXPECT);
    localparam logic [31:0] TOUT_LAST = 32'(TIMEOUT - 1);
    localparam logic [31:0] SAT       = '1;

    if (DEGLITCH_CYCLES < 1 || DEGLITCH_CYCLES > 255) begin : g_dg_range
        $error("trig_monitor: DEGLITCH_CYCLES must be 1..255");
    end

    logic [1:0]  sync_q;
    logic        filt_lvl;
    logic        prev_lvl;
    logic [1:0]  ctrl_q;
    logic        arm_prev;
    state_t      state;
    logic [31:0] per_cnt;
    logic [2:0]  sts;
    logic        edge_acc;
    logic        arm;
    logic        clr;
    logic [31:0] cnt_inc;
    logic        unused_ctrl;

    assign unused_ctrl = ^ep_ctrl[31:2];

    always_ff @(posedge clki or negedge rst_n) begin
        if (!rst_n) begin
            sync_q   <= 2'b00;
            prev_lvl <= 1'b0;
            ctrl_q   <= 2'b00;
            arm_prev <= 1'b0;
        end else begin
            sync_q   <= {sync_q[0], trig_in};
            prev_lvl <= filt_lvl;
            ctrl_q   <= ep_ctrl[1:0];
            arm_prev <= ctrl_q[0];
        end
    end

`ifdef TRIG_DEGLITCH_EN
    localparam logic [7:0] DG_LAST = 8'(DEGLITCH_CYCLES - 1);
    logic [7:0] dg_cnt;

    // Level flips only once the synchronised input has differed for DEGLITCH_CYCLES samples in a row.
    always_ff @(posedge clki or negedge rst_n) begin
        if (!rst_n) begin
            filt_lvl <= 1'b0;
            dg_cnt   <= 8'd0;
        end else if (sync_q[1] == filt_lvl) begin
            dg_cnt <= 8'd0;
        end else if (dg_cnt == DG_LAST) begin
            filt_lvl <= sync_q[1];
            dg_cnt   <= 8'd0;
        end else begin
            dg_cnt <= dg_cnt + 8'd1;
        end
    end
`else
    assign filt_lvl = sync_q[1];
`endif

    assign edge_acc  = filt_lvl & ~prev_lvl;
    assign arm       = ctrl_q[0] & ~arm_prev;
    assign clr       = ctrl_q[1];
    assign cnt_inc   = trig_count + 32'd1;
    assign ep_status = {29'd0, sts};

    always_ff @(posedge clki or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            sts         <= 3'b000;
            trig_seen   <= 1'b0;
            trig_count  <= 32'd0;
            last_period <= 32'd0;
            per_cnt     <= 32'd0;
        end else begin
            trig_seen <= 1'b0;
            if (clr) begin
                state       <= IDLE;
                sts         <= 3'b000;
                trig_count  <= 32'd0;
                last_period <= 32'd0;
                per_cnt     <= 32'd0;
            end else if (arm) begin
                state       <= ARMED;
                sts         <= 3'b001;
                trig_count  <= 32'd0;
                last_period <= 32'd0;
                per_cnt     <= 32'd0;
            end else begin
                case (state)
                    ARMED: begin
                        if (edge_acc) begin
                            trig_count <= 32'd1;
                            per_cnt    <= 32'd0;
                            trig_seen  <= 1'b1;
                            if (N_EXP == 32'd1) begin
                                state <= DONE;
                                sts   <= 3'b010;
                            end else begin
                                state <= RUN;
                                sts   <= 3'b001;
                            end
                        end
                    end
                    RUN: begin
                        // An edge in the timeout cycle still counts and keeps us running.
                        if (edge_acc) begin
                            trig_count  <= cnt_inc;
                            per_cnt     <= 32'd0;
                            trig_seen   <= 1'b1;
                            last_period <= (per_cnt == SAT) ? SAT : per_cnt + 32'd1;
                            if (N_EXP != 32'd0 && cnt_inc == N_EXP) begin
                                state <= DONE;
                                sts   <= 3'b010;
                            end
                        end else if (per_cnt == TOUT_LAST) begin
                            state <= TOUT;
                            sts   <= 3'b100;
                        end else if (per_cnt != SAT) begin
                            per_cnt <= per_cnt + 32'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule
